// File: rtl/mips_pkg.sv
// Shared core definitions: datapath width, ALU control codes and the
// multiply/divide sequencer state encoding.
package mips_pkg;

  localparam int WORD = 32;

  localparam logic [3:0] ALU_MULT = 4'b1111;
  localparam logic [3:0] ALU_DIV  = 4'b1110;
  localparam logic [3:0] ALU_MFHI = 4'b1010;
  localparam logic [3:0] ALU_MFLO = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_t;

  // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned.
  function automatic logic [WORD-1:0] abs_w(input logic [WORD-1:0] v);
    return v[WORD-1] ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// EX-stage bundle between the pipeline core and the multiply/divide sequencer.
interface muldiv_seq_if;
  import mips_pkg::*;

  logic            AnyStall;
  logic            Mult_EX;
  logic            Div_EX;
  logic            MfHi_EX;
  logic            MfLo_EX;
  logic            MtHi_EX;
  logic            MtLo_EX;
  logic [WORD-1:0] SrcA_EX;
  logic [WORD-1:0] SrcB_EX;
  logic            Stall_EX;
  logic [WORD-1:0] HiLo_EX;
  logic [WORD-1:0] Hi;
  logic [WORD-1:0] Lo;
  logic            Done;

  modport master (
    output AnyStall, Mult_EX, Div_EX, MfHi_EX, MfLo_EX, MtHi_EX, MtLo_EX,
           SrcA_EX, SrcB_EX,
    input  Stall_EX, HiLo_EX, Hi, Lo, Done
  );

  modport slave (
    input  AnyStall, Mult_EX, Div_EX, MfHi_EX, MfLo_EX, MtHi_EX, MtLo_EX,
           SrcA_EX, SrcB_EX,
    output Stall_EX, HiLo_EX, Hi, Lo, Done
  );

endinterface

// File: rtl/muldiv_iter.sv
// 64-bit accumulator with one shift-add (multiply) or restoring-subtract
// (divide) step per cycle on unsigned magnitudes.
module muldiv_iter
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              flush,
  input  logic              load,
  input  logic              step,
  input  logic              op_div,
  input  logic [WORD-1:0]   load_lo,
  input  logic [WORD-1:0]   operand,
  output logic [2*WORD-1:0] acc
);

  logic [WORD:0]     sum;
  logic [WORD:0]     trial;
  logic [2*WORD-1:0] shl;
  logic [2*WORD-1:0] next_acc;

  // Multiply keeps the multiplier in the low half and the carry of the add
  // shifts into the product; divide keeps {rem, quo}.
  always_comb begin
    sum   = {1'b0, acc[2*WORD-1:WORD]} + (acc[0] ? {1'b0, operand} : {(WORD+1){1'b0}});
    shl   = {acc[2*WORD-2:0], 1'b0};
    trial = {1'b0, shl[2*WORD-1:WORD]} - {1'b0, operand};
    if (op_div) begin
      next_acc = trial[WORD] ? shl : {trial[WORD-1:0], shl[WORD-1:1], 1'b1};
    end else begin
      next_acc = {sum, acc[WORD-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      acc <= '0;
    end else if (load) begin
      acc <= {{WORD{1'b0}}, load_lo};
    end else if (step) begin
      acc <= next_acc;
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multiply/divide sequencer and HI/LO owner beside the EX-stage ALU.
//   state | meaning
//   IDLE  | no op in flight; accepts MULT/DIV and MTHI/MTLO
//   RUN   | 32 engine steps, count 31 down to 0
//   FIX   | sign correction, HI/LO write, Done next cycle
module muldiv_seq
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        flush,
  muldiv_seq_if.slave bus
);

  md_state_t         state;
  md_state_t         state_next;
  logic [4:0]        count;
  logic              s_a;
  logic              s_b;
  logic              op_div;
  logic              b_zero;
  logic [WORD-1:0]   a_raw;
  logic [WORD-1:0]   operand;
  logic [WORD-1:0]   hi;
  logic [WORD-1:0]   lo;
  logic              done;
  logic [2*WORD-1:0] acc;

  logic              accept;
  logic              step;
  logic              stall;
  logic              mt_hi_we;
  logic              mt_lo_we;
  logic [2*WORD-1:0] prod_fix;
  logic [WORD-1:0]   fix_hi;
  logic [WORD-1:0]   fix_lo;
  logic [WORD-1:0]   load_lo;

  always_ff @(posedge clk) begin
    if (flush) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (count == 5'd0) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Stall never looks at AnyStall, which itself contains Stall_EX.
  always_comb begin
    accept   = (state == IDLE) && (bus.Mult_EX || bus.Div_EX) && !bus.AnyStall;
    mt_hi_we = (state == IDLE) && bus.MtHi_EX && !bus.AnyStall;
    mt_lo_we = (state == IDLE) && bus.MtLo_EX && !bus.AnyStall;
    step     = (state == RUN);
    stall    = (state != IDLE) && (bus.Mult_EX || bus.Div_EX || bus.MfHi_EX ||
                                   bus.MfLo_EX || bus.MtHi_EX || bus.MtLo_EX);
  end

  assign load_lo = bus.Div_EX ? abs_w(bus.SrcA_EX) : abs_w(bus.SrcB_EX);

  muldiv_iter u_iter (
    .clk     (clk),
    .flush   (flush),
    .load    (accept),
    .step    (step),
    .op_div  (op_div),
    .load_lo (load_lo),
    .operand (operand),
    .acc     (acc)
  );

  // Divide by zero bypasses sign fixing and returns the raw dividend in HI.
  always_comb begin
    prod_fix = (s_a ^ s_b) ? -acc : acc;
    fix_hi   = prod_fix[2*WORD-1:WORD];
    fix_lo   = prod_fix[WORD-1:0];
    if (op_div) begin
      if (b_zero) begin
        fix_hi = a_raw;
        fix_lo = '1;
      end else begin
        fix_lo = (s_a ^ s_b) ? -acc[WORD-1:0] : acc[WORD-1:0];
        fix_hi = s_a ? -acc[2*WORD-1:WORD] : acc[2*WORD-1:WORD];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      count <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= (state == FIX);
      if (accept) begin
        count   <= 5'd31;
        s_a     <= bus.SrcA_EX[WORD-1];
        s_b     <= bus.SrcB_EX[WORD-1];
        op_div  <= bus.Div_EX;
        b_zero  <= (bus.SrcB_EX == '0);
        a_raw   <= bus.SrcA_EX;
        operand <= bus.Div_EX ? abs_w(bus.SrcB_EX) : abs_w(bus.SrcA_EX);
      end else if (step && count != 5'd0) begin
        count <= count - 5'd1;
      end
      if (state == FIX) begin
        hi <= fix_hi;
        lo <= fix_lo;
      end else begin
        if (mt_hi_we) hi <= bus.SrcA_EX;
        if (mt_lo_we) lo <= bus.SrcA_EX;
      end
    end
  end

  assign bus.Stall_EX = stall;
  assign bus.HiLo_EX  = bus.MfHi_EX ? hi : lo;
  assign bus.Hi       = hi;
  assign bus.Lo       = lo;
  assign bus.Done     = done;

endmodule
